// File: rtl/rgmii_idelay_cal.sv
// RGMII receive IDELAY calibration: sweeps every tap, scores preamble/SFD
// integrity per tap, then programs the centre of the longest passing window.
module rgmii_idelay_cal #(
    parameter int TAP_W         = 5,
    parameter int INIT_TAP      = 0,
    parameter int SETTLE_CYCLES = 16,
    parameter int WIN_CYCLES    = 65536,
    parameter int MIN_GOOD      = 4
) (
    input  logic                    gmii_rx_clk,
    input  logic                    rst_n,
    input  logic                    cal_start,
    input  logic                    gmii_rx_dv,
    input  logic [7:0]              gmii_rxd,
    output logic [TAP_W-1:0]        idelay_value,
    output logic                    cal_busy,
    output logic                    cal_done,
    output logic                    cal_fail,
    output logic [(1<<TAP_W)-1:0]   pass_map,
    output logic [TAP_W-1:0]        win_first,
    output logic [TAP_W-1:0]        win_last
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int WW = $clog2(WIN_CYCLES + 1);
    localparam logic [TAP_W:0] ONE_LEN = 1;

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, NEXT, EVAL, DONE} state_t;
    state_t state, state_nxt;

    logic [TAP_W-1:0] tap;
    logic [SW-1:0]    settle_cnt;
    logic [WW-1:0]    win_cnt;
    logic [7:0]       good_cnt, bad_cnt;

    logic             dv_q, fr_active, fr_active_nxt, good_hit, bad_hit;
    logic [2:0]       fr_k, fr_k_nxt;

    logic [TAP_W-1:0] eval_idx, cur_start, best_first, nxt_cur_start, nxt_best_first;
    logic [TAP_W:0]   cur_len, best_len, nxt_cur_len, nxt_best_len, len_m1;

    assign cal_busy = (state != IDLE);
    assign cal_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cal_start) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = MEASURE;
            MEASURE: if (win_cnt == WW'(WIN_CYCLES - 1)) state_nxt = NEXT;
            NEXT:    state_nxt = (tap == '1) ? EVAL : SETTLE;
            EVAL:    if (eval_idx == '1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Preamble/SFD checker. Only a 0->1 edge seen inside MEASURE opens a frame,
    // so a run already in flight at window entry never gets scored.
    always_comb begin
        good_hit      = 1'b0;
        bad_hit       = 1'b0;
        fr_active_nxt = fr_active;
        fr_k_nxt      = fr_k;
        if (state != MEASURE) begin
            fr_active_nxt = 1'b0;
        end else if (gmii_rx_dv && !dv_q) begin
            fr_k_nxt = 3'd1;
            if (gmii_rxd == 8'h55) fr_active_nxt = 1'b1;
            else                   bad_hit       = 1'b1;
        end else if (fr_active) begin
            if (!gmii_rx_dv || gmii_rxd != ((fr_k == 3'd7) ? 8'hD5 : 8'h55)) begin
                bad_hit       = 1'b1;
                fr_active_nxt = 1'b0;
            end else if (fr_k == 3'd7) begin
                good_hit      = 1'b1;
                fr_active_nxt = 1'b0;
            end else begin
                fr_k_nxt = fr_k + 3'd1;
            end
        end
    end

    // One pass_map bit per EVAL cycle; strict '>' keeps the lowest run on ties.
    always_comb begin
        nxt_cur_start  = cur_start;
        nxt_cur_len    = cur_len;
        nxt_best_first = best_first;
        nxt_best_len   = best_len;
        if (pass_map[eval_idx]) begin
            if (cur_len == '0) nxt_cur_start = eval_idx;
            nxt_cur_len = cur_len + ONE_LEN;
            if (nxt_cur_len > best_len) begin
                nxt_best_first = nxt_cur_start;
                nxt_best_len   = nxt_cur_len;
            end
        end else begin
            nxt_cur_len = '0;
        end
        len_m1 = nxt_best_len - ONE_LEN;
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q      <= 1'b0;
            fr_active <= 1'b0;
            fr_k      <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            dv_q      <= gmii_rx_dv;
            fr_active <= fr_active_nxt;
            fr_k      <= fr_k_nxt;
            if (state == SETTLE) begin
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else begin
                if (good_hit && good_cnt != 8'hFF) good_cnt <= good_cnt + 8'd1;
                if (bad_hit  && bad_cnt  != 8'hFF) bad_cnt  <= bad_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tap          <= '0;
            settle_cnt   <= '0;
            win_cnt      <= '0;
            idelay_value <= TAP_W'(INIT_TAP);
            cal_fail     <= 1'b0;
            pass_map     <= '0;
            win_first    <= '0;
            win_last     <= '0;
            eval_idx     <= '0;
            cur_start    <= '0;
            cur_len      <= '0;
            best_first   <= '0;
            best_len     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (cal_start) begin
                    tap          <= '0;
                    idelay_value <= '0;
                    pass_map     <= '0;
                    cal_fail     <= 1'b0;
                    settle_cnt   <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (state_nxt == MEASURE) begin
                        settle_cnt <= '0;
                        win_cnt    <= '0;
                    end
                end
                MEASURE: win_cnt <= win_cnt + WW'(1);
                NEXT: begin
                    pass_map[tap] <= (good_cnt >= 8'(MIN_GOOD)) && (bad_cnt == 8'd0);
                    if (tap != '1) begin
                        tap          <= tap + TAP_W'(1);
                        idelay_value <= tap + TAP_W'(1);
                    end else begin
                        eval_idx   <= '0;
                        cur_start  <= '0;
                        cur_len    <= '0;
                        best_first <= '0;
                        best_len   <= '0;
                    end
                end
                EVAL: begin
                    eval_idx   <= eval_idx + TAP_W'(1);
                    cur_start  <= nxt_cur_start;
                    cur_len    <= nxt_cur_len;
                    best_first <= nxt_best_first;
                    best_len   <= nxt_best_len;
                    if (eval_idx == '1) begin
                        if (nxt_best_len == '0) begin
                            cal_fail     <= 1'b1;
                            idelay_value <= TAP_W'(INIT_TAP);
                            win_first    <= '0;
                            win_last     <= '0;
                        end else begin
                            win_first    <= nxt_best_first;
                            win_last     <= nxt_best_first + len_m1[TAP_W-1:0];
                            idelay_value <= nxt_best_first + len_m1[TAP_W:1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rgmii_idelay_cal.sv
// Directed bench: per-tap frame patterns synced to the DUT's tap stepping,
// with hand-derived pass maps, windows and centre taps.
module tb_rgmii_idelay_cal;
    localparam int TAP_W    = 5;
    localparam int INIT_TAP = 3;
    localparam int SETTLE   = 8;
    localparam int WIN      = 192;
    localparam int MING     = 4;

    logic        gmii_rx_clk = 1'b0;
    logic        rst_n, cal_start, gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic [4:0]  idelay_value, win_first, win_last;
    logic        cal_busy, cal_done, cal_fail;
    logic [31:0] pass_map;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 gmii_rx_clk = ~gmii_rx_clk;

    rgmii_idelay_cal #(
        .TAP_W(TAP_W), .INIT_TAP(INIT_TAP), .SETTLE_CYCLES(SETTLE),
        .WIN_CYCLES(WIN), .MIN_GOOD(MING)
    ) dut (
        .gmii_rx_clk(gmii_rx_clk), .rst_n(rst_n), .cal_start(cal_start),
        .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd), .idelay_value(idelay_value),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail),
        .pass_map(pass_map), .win_first(win_first), .win_last(win_last)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // kind 0: clean, 1: byte 3 corrupted, 2: dv drops after 5 bytes
    task automatic send_frame(input int kind);
        int nb;
        nb = (kind == 2) ? 5 : 28;
        for (int b = 0; b < nb; b++) begin
            @(posedge gmii_rx_clk); #1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = (b < 7) ? 8'h55 : (b == 7) ? 8'hD5 : 8'(b * 7);
            if (kind == 1 && b == 3) gmii_rxd = 8'h54;
        end
        @(posedge gmii_rx_clk); #1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        @(posedge gmii_rx_clk); #1;
    endtask

    task automatic pulse_start();
        @(posedge gmii_rx_clk); #1 cal_start = 1'b1;
        @(posedge gmii_rx_clk); #1 cal_start = 1'b0;
    endtask

    task automatic wait_tap(input int t);
        int n;
        n = 0;
        while (idelay_value !== 5'(t) && n < 400) begin
            @(negedge gmii_rx_clk);
            n++;
        end
        chk($sformatf("tap_step%0d", t), 32'(idelay_value), 32'(t));
    endtask

    task automatic sweep(input logic [31:0] mask, input int dirty, input int special,
                         input int mid_tap, input int abort_tap,
                         input logic [31:0] e_map, input int e_first, input int e_last,
                         input int e_tap, input int e_fail);
        int n;
        pulse_start();
        chk("busy_start", 32'(cal_busy), 1);
        chk("fail_clr", 32'(cal_fail), 0);
        for (int t = 0; t < 32; t++) begin
            wait_tap(t);
            repeat (SETTLE + 2) @(posedge gmii_rx_clk);
            #1;
            if (special != 0 && t == 10) begin
                repeat (4) send_frame(0);
                send_frame(2);
            end else if (special != 0 && t == 11) begin
                repeat (4) send_frame(0);
            end else if (mask[t]) begin
                repeat (5) send_frame(0);
            end else if (dirty != 0) begin
                repeat (5) send_frame(1);
            end
            if (t == mid_tap) begin
                pulse_start();
                chk("mid_busy", 32'(cal_busy), 1);
            end
            if (t == abort_tap) begin
                @(negedge gmii_rx_clk);
                rst_n = 1'b0;
                #1;
                chk("rst_idelay", 32'(idelay_value), INIT_TAP);
                chk("rst_busy", 32'(cal_busy), 0);
                chk("rst_done", 32'(cal_done), 0);
                chk("rst_map", pass_map, 0);
                chk("rst_wins", {win_first, win_last}, 0);
                repeat (2) @(posedge gmii_rx_clk);
                #1 rst_n = 1'b1;
                return;
            end
        end
        n = 0;
        while (cal_done !== 1'b1 && n < 400) begin
            @(negedge gmii_rx_clk);
            n++;
        end
        chk("done_seen", 32'(cal_done), 1);
        chk("done_busy", 32'(cal_busy), 1);
        chk("pass_map", pass_map, e_map);
        chk("win_first", 32'(win_first), 32'(e_first));
        chk("win_last", 32'(win_last), 32'(e_last));
        chk("idelay", 32'(idelay_value), 32'(e_tap));
        chk("cal_fail", 32'(cal_fail), 32'(e_fail));
        @(negedge gmii_rx_clk);
        chk("done_pulse", 32'(cal_done), 0);
        chk("idle_busy", 32'(cal_busy), 0);
        chk("fail_hold", 32'(cal_fail), 32'(e_fail));
    endtask

    initial begin
        rst_n = 1'b0; cal_start = 1'b0; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
        repeat (3) @(posedge gmii_rx_clk);
        @(negedge gmii_rx_clk);
        chk("reset_idelay", 32'(idelay_value), INIT_TAP);
        chk("reset_flags", {cal_busy, cal_done, cal_fail}, 0);
        chk("reset_map", pass_map, 0);
        chk("reset_wins", {win_first, win_last}, 0);
        @(posedge gmii_rx_clk); #1 rst_n = 1'b1;

        sweep(32'hFFFF_FFFF, 0, 0, -1, -1, 32'hFFFF_FFFF, 0, 31, 15, 0);
        sweep(32'h000F_FF00, 1, 0, -1, -1, 32'h000F_FF00, 8, 19, 13, 0);
        sweep(32'h0FF0_003C, 1, 0, -1, -1, 32'h0FF0_003C, 20, 27, 23, 0);
        sweep(32'h0000_3C3C, 1, 0, -1, -1, 32'h0000_3C3C, 2, 5, 3, 0);
        sweep(32'h0000_0000, 0, 0, -1, -1, 32'h0000_0000, 0, 0, INIT_TAP, 1);
        sweep(32'h0000_0000, 0, 1, -1, -1, 32'h0000_0800, 11, 11, 11, 0);
        sweep(32'hFFFF_FFFF, 0, 0, 6, 12, 32'h0, 0, 0, 0, 0);
        sweep(32'h0000_000F, 1, 0, -1, -1, 32'h0000_000F, 0, 3, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
